// File: rtl/req_arbiter_4_v_if.sv
// Request/grant bundle between the requesters and the arbiter.
// The master side drives requests; the slave side (the arbiter) drives grants.
interface req_arbiter_4_v_if;
    logic [3:0] i_req;
    logic       i_rr_mode;
    logic       i_release;
    logic [3:0] o_gnt;
    logic [1:0] o_gnt_id;
    logic       o_busy;
    logic       o_timeout;

    modport master (
        output i_req, i_rr_mode, i_release,
        input  o_gnt, o_gnt_id, o_busy, o_timeout
    );

    modport slave (
        input  i_req, i_rr_mode, i_release,
        output o_gnt, o_gnt_id, o_busy, o_timeout
    );
endinterface

// File: rtl/req_arbiter_4_v.sv
// Registered 4-way arbiter: fixed-priority or round-robin pick,
// grant hold limit with forced release and a one-cycle cool-down.
module req_arbiter_4_v #(
    parameter int HOLD_MAX = 8
) (
    input  logic               i_clk,
    input  logic               i_rst,
    req_arbiter_4_v_if.slave   bus
);

    localparam logic [7:0] HOLD_LIM = 8'(HOLD_MAX);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        GRANT = 2'd1,
        COOL  = 2'd2
    } state_t;

    state_t     state;
    logic [3:0] gnt_q;
    logic [1:0] gnt_id_q;
    logic       busy_q;
    logic       timeout_q;
    logic [1:0] last;
    logic [7:0] cnt;
    logic [3:0] mask;

    logic [3:0] eff;
    logic [1:0] win;
    logic [1:0] idx;
    logic       found;

    // Winner among unmasked requests under the policy chosen for this cycle.
    always_comb begin
        eff   = bus.i_req & ~mask;
        win   = 2'd0;
        idx   = 2'd0;
        found = 1'b0;
        if (bus.i_rr_mode) begin
            for (int k = 1; k <= 4; k++) begin
                idx = last + 2'(k);
                if (!found && eff[idx]) begin
                    win   = idx;
                    found = 1'b1;
                end
            end
        end else begin
            for (int k = 3; k >= 0; k--) begin
                if (eff[k]) begin
                    win   = 2'(k);
                    found = 1'b1;
                end
            end
        end
    end

    // Grant FSM; every output is a flop loaded on the state transition.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state     <= IDLE;
            gnt_q     <= 4'b0000;
            gnt_id_q  <= 2'd0;
            busy_q    <= 1'b0;
            timeout_q <= 1'b0;
            last      <= 2'd3;
            cnt       <= 8'd0;
            mask      <= 4'b0000;
        end else begin
            unique case (state)
                IDLE: begin
                    timeout_q <= 1'b0;
                    mask      <= 4'b0000;
                    if (found) begin
                        gnt_q    <= 4'b0001 << win;
                        gnt_id_q <= win;
                        busy_q   <= 1'b1;
                        cnt      <= 8'd1;
                        state    <= GRANT;
                    end
                end
                GRANT: begin
                    if (!bus.i_req[gnt_id_q] || bus.i_release) begin
                        gnt_q     <= 4'b0000;
                        timeout_q <= 1'b0;
                        state     <= COOL;
                    end else if (cnt == HOLD_LIM) begin
                        gnt_q           <= 4'b0000;
                        timeout_q       <= 1'b1;
                        mask[gnt_id_q]  <= 1'b1;
                        state           <= COOL;
                    end else begin
                        cnt <= cnt + 8'd1;
                    end
                end
                COOL: begin
                    last      <= gnt_id_q;
                    busy_q    <= 1'b0;
                    timeout_q <= 1'b0;
                    cnt       <= 8'd0;
                    state     <= IDLE;
                end
                default: begin
                    gnt_q     <= 4'b0000;
                    busy_q    <= 1'b0;
                    timeout_q <= 1'b0;
                    state     <= IDLE;
                end
            endcase
        end
    end

    assign bus.o_gnt     = gnt_q;
    assign bus.o_gnt_id  = gnt_id_q;
    assign bus.o_busy    = busy_q;
    assign bus.o_timeout = timeout_q;

endmodule

// File: tb/tb_req_arbiter_4_v.sv
// Bench for req_arbiter_4_v: two instances (hold limits 4 and 2) share
// stimulus and are compared every cycle against a transaction-level model.
module tb_req_arbiter_4_v;

    logic       clk;
    logic       rst;
    logic [3:0] req;
    logic       rr;
    logic       rel;

    int checks   = 0;
    int failures = 0;

    req_arbiter_4_v_if bus4 ();
    req_arbiter_4_v_if bus2 ();

    assign bus4.i_req     = req;
    assign bus4.i_rr_mode = rr;
    assign bus4.i_release = rel;
    assign bus2.i_req     = req;
    assign bus2.i_rr_mode = rr;
    assign bus2.i_release = rel;

    req_arbiter_4_v #(.HOLD_MAX(4)) u_dut4 (
        .i_clk (clk),
        .i_rst (rst),
        .bus   (bus4)
    );

    req_arbiter_4_v #(.HOLD_MAX(2)) u_dut2 (
        .i_clk (clk),
        .i_rst (rst),
        .bus   (bus2)
    );

    // Free-running clock, rising edges at 5, 15, 25 ...
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    logic [3:0] obs_gnt [2];
    logic [1:0] obs_id  [2];
    logic       obs_bsy [2];
    logic       obs_to  [2];

    assign obs_gnt[0] = bus4.o_gnt;
    assign obs_id[0]  = bus4.o_gnt_id;
    assign obs_bsy[0] = bus4.o_busy;
    assign obs_to[0]  = bus4.o_timeout;
    assign obs_gnt[1] = bus2.o_gnt;
    assign obs_id[1]  = bus2.o_gnt_id;
    assign obs_bsy[1] = bus2.o_busy;
    assign obs_to[1]  = bus2.o_timeout;

    // Reference model: phase 0 waiting, 1 owned, 2 cooling down.
    int         phase [2];
    int         owner [2];
    int         held  [2];
    int         prev  [2];
    logic [3:0] blk   [2];
    logic [3:0] e_gnt [2];
    logic [1:0] e_id  [2];
    logic       e_bsy [2];
    logic       e_to  [2];

    function automatic int hold_of(input int h);
        return (h == 0) ? 4 : 2;
    endfunction

    task automatic chk(input string tag, input logic [7:0] obs,
                       input logic [7:0] exp_v);
        checks++;
        assert (obs === exp_v) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp_v);
        end
    endtask

    task automatic model_reset();
        for (int h = 0; h < 2; h++) begin
            phase[h] = 0;
            owner[h] = 0;
            held[h]  = 0;
            prev[h]  = 3;
            blk[h]   = 4'b0000;
            e_gnt[h] = 4'b0000;
            e_id[h]  = 2'd0;
            e_bsy[h] = 1'b0;
            e_to[h]  = 1'b0;
        end
    endtask

    task automatic model_step(input int h);
        logic [3:0] avail;
        int         w;
        int         idx;
        e_to[h] = 1'b0;
        if (phase[h] == 0) begin
            avail  = req & ~blk[h];
            blk[h] = 4'b0000;
            if (avail != 4'b0000) begin
                w = -1;
                for (int k = 0; k < 4; k++) begin
                    idx = rr ? (prev[h] + 1 + k) % 4 : k;
                    if (w < 0 && avail[idx]) w = idx;
                end
                owner[h] = w;
                held[h]  = 1;
                phase[h] = 1;
                e_gnt[h] = 4'(1 << w);
                e_id[h]  = 2'(w);
                e_bsy[h] = 1'b1;
            end
        end else if (phase[h] == 1) begin
            if (!req[owner[h]] || rel) begin
                phase[h] = 2;
                e_gnt[h] = 4'b0000;
            end else if (held[h] == hold_of(h)) begin
                phase[h] = 2;
                e_gnt[h] = 4'b0000;
                e_to[h]  = 1'b1;
                blk[h][owner[h]] = 1'b1;
            end else begin
                held[h] = held[h] + 1;
            end
        end else begin
            prev[h]  = owner[h];
            phase[h] = 0;
            e_bsy[h] = 1'b0;
        end
    endtask

    task automatic check_model();
        for (int h = 0; h < 2; h++) begin
            chk($sformatf("m%0d_gnt", h), 8'(obs_gnt[h]), 8'(e_gnt[h]));
            chk($sformatf("m%0d_id", h), 8'(obs_id[h]), 8'(e_id[h]));
            chk($sformatf("m%0d_busy", h), 8'(obs_bsy[h]), 8'(e_bsy[h]));
            chk($sformatf("m%0d_tmo", h), 8'(obs_to[h]), 8'(e_to[h]));
            chk($sformatf("m%0d_onehot", h),
                8'($countones(obs_gnt[h]) <= 1), 8'd1);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        model_step(0);
        model_step(1);
        #1;
        check_model();
    endtask

    task automatic do_reset();
        rst = 1'b1;
        req = 4'b0000;
        rr  = 1'b0;
        rel = 1'b0;
        #2;
        model_reset();
        check_model();
        #1;
        rst = 1'b0;
    endtask

    // Directed steps from the test plan, then a randomized soak.
    initial begin
        int n;
        rst = 1'b1;
        req = 4'b0000;
        rr  = 1'b0;
        rel = 1'b0;
        #1;
        model_reset();
        chk("rst_gnt", 8'(bus4.o_gnt), 8'h0);
        chk("rst_busy", 8'(bus4.o_busy), 8'h0);
        @(posedge clk);
        #1;
        do_reset();

        // Fixed priority
        rr  = 1'b0;
        req = 4'b1010;
        cyc();
        chk("fp_c1_gnt", 8'(bus4.o_gnt), 8'h2);
        chk("fp_c1_id", 8'(bus4.o_gnt_id), 8'h1);
        chk("fp_c1_busy", 8'(bus4.o_busy), 8'h1);
        cyc();
        req = 4'b1000;
        cyc();
        chk("fp_c3_gnt", 8'(bus4.o_gnt), 8'h0);
        cyc();
        cyc();
        chk("fp_c5_gnt", 8'(bus4.o_gnt), 8'h8);
        chk("fp_c5_id", 8'(bus4.o_gnt_id), 8'h3);
        req = 4'b0000;
        repeat (4) cyc();

        // Ignored inputs
        rel = 1'b1;
        cyc();
        rel = 1'b0;
        chk("ig_idle_gnt", 8'(bus4.o_gnt), 8'h0);
        chk("ig_idle_busy", 8'(bus4.o_busy), 8'h0);
        req = 4'b0100;
        cyc();
        chk("ig_c1_gnt", 8'(bus4.o_gnt), 8'h4);
        req = 4'b0110;
        cyc();
        chk("ig_c2_gnt", 8'(bus4.o_gnt), 8'h4);
        cyc();
        chk("ig_c3_gnt", 8'(bus4.o_gnt), 8'h4);
        rel = 1'b1;
        cyc();
        rel = 1'b0;
        req = 4'b0000;
        chk("ig_c4_gnt", 8'(bus4.o_gnt), 8'h0);
        repeat (4) cyc();

        // Round-robin rotation
        do_reset();
        rr  = 1'b1;
        req = 4'b1111;
        cyc();
        for (int i = 0; i < 5; i++) begin
            chk($sformatf("rr_g%0d", i), 8'(bus4.o_gnt), 8'(1 << (i % 4)));
            rel = 1'b1;
            cyc();
            rel = 1'b0;
            cyc();
            cyc();
        end
        req = 4'b0000;
        repeat (4) cyc();

        // Timeout on the hold-4 instance
        do_reset();
        req = 4'b0001;
        for (int c = 1; c <= 4; c++) begin
            cyc();
            chk($sformatf("to_c%0d_gnt", c), 8'(bus4.o_gnt), 8'h1);
            chk($sformatf("to_c%0d_tmo", c), 8'(bus4.o_timeout), 8'h0);
        end
        cyc();
        chk("to_c5_tmo", 8'(bus4.o_timeout), 8'h1);
        chk("to_c5_gnt", 8'(bus4.o_gnt), 8'h0);
        cyc();
        chk("to_c6_tmo", 8'(bus4.o_timeout), 8'h0);
        cyc();
        chk("to_c7_gnt", 8'(bus4.o_gnt), 8'h0);
        cyc();
        chk("to_c8_gnt", 8'(bus4.o_gnt), 8'h1);
        req = 4'b0000;
        repeat (4) cyc();

        // Release beats timeout on the hold-2 instance
        do_reset();
        req = 4'b0100;
        cyc();
        chk("rb_c1_gnt", 8'(bus2.o_gnt), 8'h4);
        cyc();
        chk("rb_c2_gnt", 8'(bus2.o_gnt), 8'h4);
        rel = 1'b1;
        cyc();
        rel = 1'b0;
        req = 4'b0000;
        chk("rb_c3_gnt", 8'(bus2.o_gnt), 8'h0);
        chk("rb_c3_tmo", 8'(bus2.o_timeout), 8'h0);
        repeat (3) cyc();

        // Asynchronous reset in the middle of a grant
        req = 4'b0001;
        n = 0;
        while (bus4.o_gnt !== 4'b0001 && n < 10) begin
            cyc();
            n++;
        end
        chk("ar_wait_gnt", 8'(bus4.o_gnt), 8'h1);
        #2;
        rst = 1'b1;
        #1;
        chk("ar_gnt", 8'(bus4.o_gnt), 8'h0);
        chk("ar_id", 8'(bus4.o_gnt_id), 8'h0);
        chk("ar_busy", 8'(bus4.o_busy), 8'h0);
        chk("ar_tmo", 8'(bus4.o_timeout), 8'h0);
        model_reset();
        req = 4'b0000;
        #2;
        rst = 1'b0;
        repeat (3) cyc();

        // Randomized soak against the model
        for (int i = 0; i < 600; i++) begin
            req = 4'($urandom_range(0, 15));
            rr  = 1'($urandom_range(0, 1));
            rel = ($urandom_range(0, 7) == 0);
            cyc();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
